retire_buffer: RTL and testbench

//  In-order retire buffer that feeds the commit stage. It allocates one entry per issued instruction
//  and captures functional-unit writebacks by transaction ID. Up to NR_COMMIT_PORTS head entries that

---
 rtl/retire_buffer.sv | 160 ++++++++++++++++
 tb/tb_retire_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_buffer.sv
// In-order retire buffer: allocates entries at issue, captures writebacks by ID,
// and presents the completed in-order head entries to commit, popping them on ack.
module retire_buffer #(
    parameter int unsigned NR_ENTRIES      = 8,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_WB_PORTS     = 4,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned VLEN            = 39,
    parameter int unsigned TID_W           = $clog2(NR_ENTRIES)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             issue_valid_i,
    output logic                             issue_ready_o,
    input  logic [VLEN-1:0]                  issue_pc_i,
    input  logic [4:0]                       issue_rd_i,
    input  logic                             issue_fpr_i,
    output logic [TID_W-1:0]                 issue_tid_o,
    input  logic [NR_WB_PORTS-1:0]           wb_valid_i,
    input  logic [NR_WB_PORTS*TID_W-1:0]     wb_tid_i,
    input  logic [NR_WB_PORTS*XLEN-1:0]      wb_data_i,
    input  logic [NR_WB_PORTS-1:0]           wb_ex_i,
    output logic [NR_COMMIT_PORTS-1:0]       commit_valid_o,
    output logic [NR_COMMIT_PORTS*VLEN-1:0]  commit_pc_o,
    output logic [NR_COMMIT_PORTS*5-1:0]     commit_rd_o,
    output logic [NR_COMMIT_PORTS-1:0]       commit_fpr_o,
    output logic [NR_COMMIT_PORTS*XLEN-1:0]  commit_result_o,
    output logic [NR_COMMIT_PORTS-1:0]       commit_ex_o,
    output logic [TID_W-1:0]                 commit_tid_o,
    input  logic [NR_COMMIT_PORTS-1:0]       commit_ack_i
);

    localparam int unsigned CNT_W = TID_W + 1;
    localparam int unsigned POP_W = $clog2(NR_COMMIT_PORTS + 1);

    typedef struct packed {
        logic            occ;
        logic            done;
        logic            ex;
        logic [VLEN-1:0] pc;
        logic [4:0]      rd;
        logic            fpr;
        logic [XLEN-1:0] result;
    } entry_t;

    entry_t            mem_q [NR_ENTRIES];
    entry_t            mem_d [NR_ENTRIES];
    logic [TID_W-1:0]  head_q, head_d;
    logic [TID_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [TID_W-1:0]            commit_idx [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0]  cvalid;
    logic                        valid_chain;
    logic                        ack_run;
    logic [POP_W-1:0]            pop_cnt;
    logic                        issue_fire;

    // Allocation is gated by registered occupancy only; same-cycle pops do not free space.
    assign issue_ready_o = ~rst_i & ~flush_i & (count_q < CNT_W'(NR_ENTRIES));
    assign issue_fire    = issue_valid_i & issue_ready_o;
    assign issue_tid_o   = tail_q;
    assign commit_tid_o  = head_q;

    for (genvar k = 0; k < NR_COMMIT_PORTS; k++) begin : g_commit
        assign commit_idx[k]                     = head_q + TID_W'(k);
        assign commit_pc_o[k*VLEN +: VLEN]       = mem_q[commit_idx[k]].pc;
        assign commit_rd_o[k*5 +: 5]             = mem_q[commit_idx[k]].rd;
        assign commit_fpr_o[k]                   = mem_q[commit_idx[k]].fpr;
        assign commit_result_o[k*XLEN +: XLEN]   = mem_q[commit_idx[k]].result;
        assign commit_ex_o[k]                    = mem_q[commit_idx[k]].ex;
    end

    // A port is valid only if every older port is valid as well.
    always_comb begin
        valid_chain = 1'b1;
        cvalid      = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            valid_chain = valid_chain & mem_q[commit_idx[k]].occ & mem_q[commit_idx[k]].done;
            cvalid[k]   = valid_chain;
        end
    end

    assign commit_valid_o = cvalid;

    // Only the leading run of acks on valid ports retires entries.
    always_comb begin
        ack_run = 1'b1;
        pop_cnt = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            ack_run = ack_run & commit_ack_i[k] & cvalid[k];
            if (ack_run) begin
                pop_cnt = pop_cnt + POP_W'(1);
            end
        end
    end

    // Next-state: issue, writeback (higher port wins), pop, then flush overrides all.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (issue_fire) begin
            mem_d[tail_q].occ  = 1'b1;
            mem_d[tail_q].done = 1'b0;
            mem_d[tail_q].ex   = 1'b0;
            mem_d[tail_q].pc   = issue_pc_i;
            mem_d[tail_q].rd   = issue_rd_i;
            mem_d[tail_q].fpr  = issue_fpr_i;
            tail_d             = tail_q + TID_W'(1);
        end

        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p] && mem_q[wb_tid_i[p*TID_W +: TID_W]].occ) begin
                mem_d[wb_tid_i[p*TID_W +: TID_W]].done   = 1'b1;
                mem_d[wb_tid_i[p*TID_W +: TID_W]].ex     = wb_ex_i[p];
                mem_d[wb_tid_i[p*TID_W +: TID_W]].result = wb_data_i[p*XLEN +: XLEN];
            end
        end

        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (k < int'(pop_cnt)) begin
                mem_d[commit_idx[k]].occ  = 1'b0;
                mem_d[commit_idx[k]].done = 1'b0;
            end
        end

        head_d  = head_q + TID_W'(pop_cnt);
        count_d = count_q + CNT_W'(issue_fire) - CNT_W'(pop_cnt);

        if (flush_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_retire_buffer.sv
// Randomized and directed bench for retire_buffer against an in-order queue model.
module tb_retire_buffer;

    localparam int N   = 8;
    localparam int NC  = 2;
    localparam int NW  = 4;
    localparam int XL  = 64;
    localparam int VL  = 39;
    localparam int TW  = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [VL-1:0]     issue_pc_i;
    logic [4:0]        issue_rd_i;
    logic              issue_fpr_i;
    logic [TW-1:0]     issue_tid_o;
    logic [NW-1:0]     wb_valid_i;
    logic [NW*TW-1:0]  wb_tid_i;
    logic [NW*XL-1:0]  wb_data_i;
    logic [NW-1:0]     wb_ex_i;
    logic [NC-1:0]     commit_valid_o;
    logic [NC*VL-1:0]  commit_pc_o;
    logic [NC*5-1:0]   commit_rd_o;
    logic [NC-1:0]     commit_fpr_o;
    logic [NC*XL-1:0]  commit_result_o;
    logic [NC-1:0]     commit_ex_o;
    logic [TW-1:0]     commit_tid_o;
    logic [NC-1:0]     commit_ack_i;

    retire_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_pc_i(issue_pc_i), .issue_rd_i(issue_rd_i), .issue_fpr_i(issue_fpr_i),
        .issue_tid_o(issue_tid_o),
        .wb_valid_i(wb_valid_i), .wb_tid_i(wb_tid_i), .wb_data_i(wb_data_i), .wb_ex_i(wb_ex_i),
        .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .commit_rd_o(commit_rd_o),
        .commit_fpr_o(commit_fpr_o), .commit_result_o(commit_result_o), .commit_ex_o(commit_ex_o),
        .commit_tid_o(commit_tid_o), .commit_ack_i(commit_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          tid;
        bit          done;
        bit          ex;
        logic [38:0] pc;
        logic [4:0]  rd;
        bit          fpr;
        logic [63:0] res;
    } rec_t;

    rec_t q[$];
    int   head_m = 0;
    int   tail_m = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC-1:0] model_valid();
        logic [NC-1:0] v = '0;
        bit ok = 1'b1;
        for (int k = 0; k < NC; k++) begin
            ok = ok && (k < q.size()) && q[k].done;
            v[k] = ok;
        end
        return v;
    endfunction

    function automatic void model_clear();
        q.delete();
        head_m = 0;
        tail_m = 0;
    endfunction

    // Called at a negedge: checks outputs, drives one cycle of inputs, advances the model.
    task automatic step(input bit iv, input logic [38:0] pc, input logic [4:0] rd, input bit fpr,
                        input logic [3:0] wbv, input logic [11:0] wbt, input logic [255:0] wbd,
                        input logic [3:0] wbe, input logic [1:0] ack, input bit fl);
        logic [NC-1:0] ev;
        bit run;
        int npop;
        bit exp_ready;
        rec_t r;
        ev = model_valid();
        check("commit_valid", 64'(commit_valid_o), 64'(ev));
        check("commit_tid", 64'(commit_tid_o), 64'(head_m));
        check("issue_tid", 64'(issue_tid_o), 64'(tail_m));
        for (int k = 0; k < NC; k++) begin
            if (ev[k]) begin
                check("commit_pc", 64'(commit_pc_o[k*VL +: VL]), 64'(q[k].pc));
                check("commit_rd", 64'(commit_rd_o[k*5 +: 5]), 64'(q[k].rd));
                check("commit_fpr", 64'(commit_fpr_o[k]), 64'(q[k].fpr));
                check("commit_result", commit_result_o[k*XL +: XL], q[k].res);
                check("commit_ex", 64'(commit_ex_o[k]), 64'(q[k].ex));
            end
        end
        issue_valid_i = iv; issue_pc_i = pc; issue_rd_i = rd; issue_fpr_i = fpr;
        wb_valid_i = wbv; wb_tid_i = wbt; wb_data_i = wbd; wb_ex_i = wbe;
        commit_ack_i = ack; flush_i = fl;
        #1;
        exp_ready = (q.size() < N) && !fl;
        check("issue_ready", 64'(issue_ready_o), 64'(exp_ready));
        if (fl) begin
            model_clear();
        end else begin
            run = 1'b1;
            npop = 0;
            for (int k = 0; k < NC; k++) begin
                run = run && ack[k] && ev[k];
                if (run) npop++;
            end
            for (int p = 0; p < NW; p++) begin
                if (wbv[p]) begin
                    foreach (q[i]) begin
                        if (q[i].tid == int'(wbt[p*TW +: TW])) begin
                            q[i].done = 1'b1;
                            q[i].ex   = wbe[p];
                            q[i].res  = wbd[p*XL +: XL];
                        end
                    end
                end
            end
            for (int k = 0; k < npop; k++) void'(q.pop_front());
            head_m = (head_m + npop) % N;
            if (iv && exp_ready) begin
                r.tid = tail_m; r.done = 1'b0; r.ex = 1'b0;
                r.pc = pc; r.rd = rd; r.fpr = fpr; r.res = '0;
                q.push_back(r);
                tail_m = (tail_m + 1) % N;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 4'b0, 12'b0, 256'b0, 4'b0, 2'b0, 0);
    endtask

    task automatic issue(input logic [38:0] pc, input logic [4:0] rd);
        step(1, pc, rd, 0, 4'b0, 12'b0, 256'b0, 4'b0, 2'b0, 0);
    endtask

    task automatic wb1(input logic [2:0] tid, input logic [63:0] d);
        step(0, 0, 0, 0, 4'b0001, 12'(tid), 256'(d), 4'b0, 2'b0, 0);
    endtask

    task automatic ack_only(input logic [1:0] a);
        step(0, 0, 0, 0, 4'b0, 12'b0, 256'b0, 4'b0, a, 0);
    endtask

    task automatic rand_step();
        logic [11:0]  t;
        logic [255:0] d;
        for (int p = 0; p < NW; p++) begin
            if (q.size() > 0 && ($urandom % 4) != 0)
                t[p*TW +: TW] = TW'(q[$urandom_range(0, q.size() - 1)].tid);
            else
                t[p*TW +: TW] = TW'($urandom % N);
            d[p*XL +: XL] = {$urandom, $urandom};
        end
        step(($urandom % 10) < 6, 39'({$urandom, $urandom}), 5'($urandom), 1'($urandom),
             4'($urandom) & 4'($urandom), t, d, 4'(($urandom % 8) == 0 ? 4'($urandom) : 4'b0),
             2'($urandom), ($urandom % 50) == 0);
    endtask

    task automatic mid_reset();
        rst_i = 1'b1;
        #1;
        check("rst_ready", 64'(issue_ready_o), 64'd0);
        check("rst_valid", 64'(commit_valid_o), 64'd0);
        check("rst_issue_tid", 64'(issue_tid_o), 64'd0);
        check("rst_commit_tid", 64'(commit_tid_o), 64'd0);
        check("rst_result", commit_result_o[63:0], 64'd0);
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 0; issue_valid_i = 0; issue_pc_i = '0; issue_rd_i = '0;
        issue_fpr_i = 0; wb_valid_i = '0; wb_tid_i = '0; wb_data_i = '0; wb_ex_i = '0;
        commit_ack_i = '0;
        @(negedge clk_i);
        mid_reset();

        // Basic issue, writeback and single pop
        issue(39'h100, 5'd1);
        issue(39'h104, 5'd2);
        wb1(3'd0, 64'hAA);
        check("t1_valid", 64'(commit_valid_o), 64'd1);
        check("t1_result", commit_result_o[63:0], 64'hAA);
        ack_only(2'b01);
        check("t1_head", 64'(commit_tid_o), 64'd1);

        // Out-of-order completion holds commit until the head completes
        issue(39'h108, 5'd3);
        wb1(3'd2, 64'hBB);
        check("t2_wait", 64'(commit_valid_o), 64'd0);
        wb1(3'd1, 64'hCC);
        check("t2_both", 64'(commit_valid_o), 64'd3);
        ack_only(2'b11);
        check("t2_empty", 64'(commit_valid_o), 64'd0);
        check("t2_head", 64'(commit_tid_o), 64'd3);

        // Full buffer: ack in the same cycle does not let an issue through
        step(0, 0, 0, 0, 4'b0, 12'b0, 256'b0, 4'b0, 2'b0, 1);
        for (int i = 0; i < N; i++) issue(39'(32'h200 + 4 * i), 5'(i));
        check("t3_full", 64'(issue_ready_o), 64'd0);
        step(0, 0, 0, 0, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, {4{64'h1234}}, 4'b0, 2'b0, 0);
        step(0, 0, 0, 0, 4'b1111, {3'd7, 3'd6, 3'd5, 3'd4}, {4{64'h5678}}, 4'b0010, 2'b0, 0);
        step(1, 39'h300, 5'd9, 0, 4'b0, 12'b0, 256'b0, 4'b0, 2'b01, 0);
        check("t3_ready_back", 64'(issue_ready_o), 64'd1);
        check("t3_wrap_tid", 64'(issue_tid_o), 64'd0);
        issue(39'h304, 5'd10);
        check("t3_after_wrap", 64'(issue_tid_o), 64'd1);

        // Non-prefix ack is ignored; ack beyond the valid run pops only the valid part
        ack_only(2'b10);
        check("t4_gap", 64'(commit_tid_o), 64'd1);
        step(0, 0, 0, 0, 4'b0, 12'b0, 256'b0, 4'b0, 2'b0, 1);
        issue(39'h400, 5'd1);
        issue(39'h404, 5'd2);
        wb1(3'd0, 64'h44);
        ack_only(2'b11);
        check("t4_one_pop", 64'(commit_tid_o), 64'd1);

        // Two ports hitting one ID: highest port index wins
        step(0, 0, 0, 0, 4'b0, 12'b0, 256'b0, 4'b0, 2'b0, 1);
        for (int i = 0; i < 4; i++) issue(39'(32'h500 + 4 * i), 5'(i));
        step(0, 0, 0, 0, 4'b1010, {3'd3, 3'd0, 3'd3, 3'd0},
             {64'h22, 64'h0, 64'h11, 64'h0}, 4'b0, 2'b0, 0);
        step(0, 0, 0, 0, 4'b0111, {3'd0, 3'd2, 3'd1, 3'd0},
             {64'h0, 64'h3, 64'h2, 64'h1}, 4'b0, 2'b0, 0);
        ack_only(2'b11);
        ack_only(2'b01);
        check("t5_valid", 64'(commit_valid_o), 64'd1);
        check("t5_result", commit_result_o[63:0], 64'h22);

        // Flush with concurrent issue and ack
        step(0, 0, 0, 0, 4'b0, 12'b0, 256'b0, 4'b0, 2'b0, 1);
        for (int i = 0; i < 5; i++) issue(39'(32'h600 + 4 * i), 5'(i));
        step(0, 0, 0, 0, 4'b0011, {6'd0, 3'd1, 3'd0}, {128'h0, 64'h7, 64'h6}, 4'b0, 2'b0, 0);
        step(1, 39'h700, 5'd7, 0, 4'b0, 12'b0, 256'b0, 4'b0, 2'b11, 1);
        check("t6_valid", 64'(commit_valid_o), 64'd0);
        check("t6_issue_tid", 64'(issue_tid_o), 64'd0);
        check("t6_commit_tid", 64'(commit_tid_o), 64'd0);

        for (int i = 0; i < 300; i++) rand_step();
        mid_reset();
        for (int i = 0; i < 300; i++) rand_step();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
